// File: rtl/spart_rx.sv
// ----------------------------------------------------------------------------
// spart_rx -- serial receive stage of mini-spart
//
// Purpose:
//    Deserialises 8N1 frames (start 0, eight data bits LSB first, stop 1) from
//    the asynchronous RxD line. The line is oversampled on the baud tick `en`
//    (OVERSAMPLE ticks per bit). Each completed byte is presented on `data`
//    with a sticky `rda` flag that the consumer clears with `clr_rda`.
//
// Parameters:
//    OVERSAMPLE   en ticks per bit period (power of two, >= 8)
//    SYNC_STAGES  flops in the RxD synchroniser (>= 2)
//
// Ports:
//    clk      in   system clock
//    rst      in   asynchronous, active-high reset
//    en       in   baud tick, one-clk pulse, OVERSAMPLE per bit period
//    RxD      in   asynchronous serial line, idle high
//    clr_rda  in   one-clk pulse: byte consumed; clears rda and ovr
//    data     out  last complete received byte
//    rda      out  receive data available (sticky until clr_rda)
//    ovr      out  overrun: a frame completed while rda was still set
//    ferr     out  framing error (bad stop bit) on the last frame
//
// Build option:
//    SPART_RX_FERR_EN  when defined, the stop bit is checked and ferr is
//                      driven from it; otherwise ferr is constant 0.
// ----------------------------------------------------------------------------
module spart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       RxD,
   input  logic       clr_rda,
   output logic [7:0] data,
   output logic       rda,
   output logic       ovr,
   output logic       ferr
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [TW-1:0]          tick_q;
   logic [2:0]             bit_q;
   logic [7:0]             shift_q;
   logic [7:0]             data_q;
   logic [7:0]             data_d;
   logic                   rda_q;
   logic                   rda_d;
   logic                   ovr_q;
   logic                   ovr_d;
   // Set once IDLE has seen the line high on a tick; a start is only
   // accepted on a falling edge, so a held-low break cannot retrigger.
   logic                   armed_q;
   logic                   frame_done;

   assign rxs = sync_q[SYNC_STAGES-1];

   // Stop-bit sample tick: the frame completes in this clk.
   assign frame_done = en && (state_q == STOP) && (tick_q == TICK_LAST);

   // ------------------------------------------------------------------------
   // Metastability synchroniser, resets to the idle (high) line level.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
      end
   end

   // ------------------------------------------------------------------------
   // Receive FSM: start detect, mid-bit sampling, shift register.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= 8'h00;
         armed_q <= 1'b0;
      end else if (en) begin
         case (state_q)
            IDLE: begin
               if (rxs) begin
                  armed_q <= 1'b1;
               end else if (armed_q) begin
                  armed_q <= 1'b0;
                  state_q <= START;
                  tick_q  <= '0;
               end
            end
            START: begin
               if (tick_q == HALF_LAST) begin
                  // Mid start bit: a high line means the edge was a glitch.
                  if (rxs) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= DATA;
                     tick_q  <= '0;
                     bit_q   <= '0;
                  end
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end
            DATA: begin
               if (tick_q == TICK_LAST) begin
                  shift_q <= {rxs, shift_q[7:1]};
                  tick_q  <= '0;
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end
            STOP: begin
               // Leaving at mid stop bit allows resync on the next edge.
               if (tick_q == TICK_LAST) begin
                  state_q <= IDLE;
                  tick_q  <= '0;
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Consumer-side flags. A completing frame takes priority over clr_rda, so
   // the new byte is never lost; a simultaneous clear only drops ovr.
   // ------------------------------------------------------------------------
   always_comb begin
      data_d = data_q;
      rda_d  = rda_q;
      ovr_d  = ovr_q;
      if (clr_rda) begin
         rda_d = 1'b0;
         ovr_d = 1'b0;
      end
      if (frame_done) begin
         data_d = shift_q;
         rda_d  = 1'b1;
         if (rda_q && !clr_rda) begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= 8'h00;
         rda_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         rda_q  <= rda_d;
         ovr_q  <= ovr_d;
      end
   end

   assign data = data_q;
   assign rda  = rda_q;
   assign ovr  = ovr_q;

`ifdef SPART_RX_FERR_EN
   logic ferr_q;

   // Stop bit must be high; the flag persists until the next frame completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ferr_q <= 1'b0;
      end else if (frame_done) begin
         ferr_q <= ~rxs;
      end
   end

   assign ferr = ferr_q;
`else
   assign ferr = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// ----------------------------------------------------------------------------
// tb_spart_rx -- directed testbench for spart_rx (OVERSAMPLE=16, SYNC=2).
// The baud tick is one clk high every four clks. RxD is changed together
// with the tick, so the synchronised line lags by exactly one tick. With the
// line dropping before frame tick 0, the stop bit is sampled on frame tick
// 153 and rda is visible right after that tick's clock edge.
// ----------------------------------------------------------------------------
module tb_spart_rx;

   logic       clk;
   logic       rst;
   logic       en;
   logic       RxD;
   logic       clr_rda;
   logic [7:0] data;
   logic       rda;
   logic       ovr;
   logic       ferr;

   int n_cmp;
   int n_err;

`ifdef SPART_RX_FERR_EN
   localparam logic FERR_ON = 1'b1;
`else
   localparam logic FERR_ON = 1'b0;
`endif

   spart_rx #(
      .OVERSAMPLE  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .RxD     (RxD),
      .clr_rda (clr_rda),
      .data    (data),
      .rda     (rda),
      .ovr     (ovr),
      .ferr    (ferr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One baud tick: en high for one clk, then three idle clks.
   task automatic tick(input logic rxd_v, input logic clr_v);
      RxD     = rxd_v;
      en      = 1'b1;
      clr_rda = clr_v;
      @(negedge clk);
      en      = 1'b0;
      clr_rda = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   task automatic pulse_clr();
      clr_rda = 1'b1;
      @(negedge clk);
      clr_rda = 1'b0;
      @(negedge clk);
   endtask

   // Drive frame ticks first..last (16 ticks per bit, 160 per frame).
   task automatic drive_frame(input logic [7:0] b, input logic stop_v,
                              input int first, input int last);
      logic [7:0] bv;
      bv = b;
      for (int t = first; t <= last; t++) begin
         int   idx;
         logic v;
         idx = t / 16;
         if (idx == 0)      v = 1'b0;
         else if (idx <= 8) v = bv[idx-1];
         else if (idx == 9) v = stop_v;
         else               v = 1'b1;
         tick(v, 1'b0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; RxD = 1'b1; clr_rda = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      idle_ticks(100);
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL reset_rda got=%b want=0", rda); end
      n_cmp++; if (ovr !== 1'b0)    begin n_err++; $display("FAIL reset_ovr got=%b want=0", ovr); end
      n_cmp++; if (ferr !== 1'b0)   begin n_err++; $display("FAIL reset_ferr got=%b want=0", ferr); end
      n_cmp++; if (data !== 8'h00)  begin n_err++; $display("FAIL reset_data got=%h want=00", data); end
      $display("reset + 100 idle ticks: data=%h rda=%b ovr=%b ferr=%b", data, rda, ovr, ferr);
   endtask

   task automatic test_frame_a5();
      drive_frame(8'hA5, 1'b1, 0, 152);
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL a5_early_rda got=%b want=0", rda); end
      drive_frame(8'hA5, 1'b1, 153, 153);
      n_cmp++; if (rda !== 1'b1)    begin n_err++; $display("FAIL a5_rda got=%b want=1", rda); end
      n_cmp++; if (data !== 8'hA5)  begin n_err++; $display("FAIL a5_data got=%h want=a5", data); end
      n_cmp++; if (ovr !== 1'b0)    begin n_err++; $display("FAIL a5_ovr got=%b want=0", ovr); end
      drive_frame(8'hA5, 1'b1, 154, 159);
      pulse_clr();
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL a5_clr_rda got=%b want=0", rda); end
      n_cmp++; if (data !== 8'hA5)  begin n_err++; $display("FAIL a5_clr_data got=%h want=a5", data); end
      $display("frame 0xA5: data=%h rda=%b after clear", data, rda);
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
      idle_ticks(24);
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL glitch_rda got=%b want=0", rda); end
      drive_frame(8'h3C, 1'b1, 0, 159);
      n_cmp++; if (rda !== 1'b1)    begin n_err++; $display("FAIL post_glitch_rda got=%b want=1", rda); end
      n_cmp++; if (data !== 8'h3C)  begin n_err++; $display("FAIL post_glitch_data got=%h want=3c", data); end
      $display("glitch then frame 0x3C: data=%h rda=%b", data, rda);
      pulse_clr();
   endtask

   task automatic test_overrun();
      drive_frame(8'h11, 1'b1, 0, 159);
      n_cmp++; if (ovr !== 1'b0)    begin n_err++; $display("FAIL ovr_first got=%b want=0", ovr); end
      drive_frame(8'h22, 1'b1, 0, 159);
      n_cmp++; if (data !== 8'h22)  begin n_err++; $display("FAIL ovr_data got=%h want=22", data); end
      n_cmp++; if (rda !== 1'b1)    begin n_err++; $display("FAIL ovr_rda got=%b want=1", rda); end
      n_cmp++; if (ovr !== 1'b1)    begin n_err++; $display("FAIL ovr_flag got=%b want=1", ovr); end
      $display("frames 0x11,0x22 no clear: data=%h rda=%b ovr=%b", data, rda, ovr);
      // Completion coincident with clr_rda: new byte kept, ovr cleared.
      drive_frame(8'h33, 1'b1, 0, 152);
      tick(1'b1, 1'b1);
      n_cmp++; if (data !== 8'h33)  begin n_err++; $display("FAIL simul_data got=%h want=33", data); end
      n_cmp++; if (rda !== 1'b1)    begin n_err++; $display("FAIL simul_rda got=%b want=1", rda); end
      n_cmp++; if (ovr !== 1'b0)    begin n_err++; $display("FAIL simul_ovr got=%b want=0", ovr); end
      drive_frame(8'h33, 1'b1, 154, 159);
      $display("frame 0x33 with clear on completion: data=%h rda=%b ovr=%b", data, rda, ovr);
      drive_frame(8'h44, 1'b1, 0, 159);
      n_cmp++; if (ovr !== 1'b1)    begin n_err++; $display("FAIL ovr_again got=%b want=1", ovr); end
      pulse_clr();
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL ovr_clr_rda got=%b want=0", rda); end
      n_cmp++; if (ovr !== 1'b0)    begin n_err++; $display("FAIL ovr_clr_ovr got=%b want=0", ovr); end
      $display("overrun cleared: rda=%b ovr=%b", rda, ovr);
   endtask

   task automatic test_ferr();
      drive_frame(8'h7E, 1'b0, 0, 159);
      idle_ticks(8);
      n_cmp++; if (data !== 8'h7E)  begin n_err++; $display("FAIL ferr_data got=%h want=7e", data); end
      n_cmp++; if (rda !== 1'b1)    begin n_err++; $display("FAIL ferr_rda got=%b want=1", rda); end
      n_cmp++; if (ferr !== FERR_ON) begin n_err++; $display("FAIL ferr_flag got=%b want=%b", ferr, FERR_ON); end
      $display("frame 0x7E bad stop: data=%h rda=%b ferr=%b", data, rda, ferr);
      pulse_clr();
   endtask

   task automatic test_break();
      for (int i = 0; i < 160; i++) tick(1'b0, 1'b0);
      n_cmp++; if (rda !== 1'b1)    begin n_err++; $display("FAIL break_rda got=%b want=1", rda); end
      n_cmp++; if (data !== 8'h00)  begin n_err++; $display("FAIL break_data got=%h want=00", data); end
      pulse_clr();
      for (int i = 0; i < 200; i++) tick(1'b0, 1'b0);
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL break_rearm got=%b want=0", rda); end
      idle_ticks(20);
      drive_frame(8'hC3, 1'b1, 0, 159);
      n_cmp++; if (data !== 8'hC3)  begin n_err++; $display("FAIL after_break_data got=%h want=c3", data); end
      n_cmp++; if (ferr !== 1'b0)   begin n_err++; $display("FAIL after_break_ferr got=%b want=0", ferr); end
      $display("break then frame 0xC3: data=%h rda=%b ferr=%b", data, rda, ferr);
   endtask

   task automatic test_reset_midframe();
      // rda/data still hold 0xC3 here; reset must clear them asynchronously.
      drive_frame(8'hFF, 1'b1, 0, 80);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL rst_async_rda got=%b want=0", rda); end
      n_cmp++; if (data !== 8'h00)  begin n_err++; $display("FAIL rst_async_data got=%h want=00", data); end
      @(negedge clk);
      RxD = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      idle_ticks(20);
      n_cmp++; if (rda !== 1'b0)    begin n_err++; $display("FAIL rst_partial_rda got=%b want=0", rda); end
      drive_frame(8'h5A, 1'b1, 0, 159);
      n_cmp++; if (data !== 8'h5A)  begin n_err++; $display("FAIL rst_next_data got=%h want=5a", data); end
      n_cmp++; if (rda !== 1'b1)    begin n_err++; $display("FAIL rst_next_rda got=%b want=1", rda); end
      n_cmp++; if (ovr !== 1'b0)    begin n_err++; $display("FAIL rst_next_ovr got=%b want=0", ovr); end
      $display("reset mid-frame then 0x5A: data=%h rda=%b ovr=%b", data, rda, ovr);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_frame_a5();
      test_glitch();
      test_overrun();
      test_ferr();
      test_break();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
